alu_seq_32_bits: RTL and testbench

Registered 32-bit execute stage that consumes two operands and an opcode and produces a registered result with zero and overflow flags.
- Single-cycle logic and arithmetic ops complete in 1 cycle.
- Unsigned multiply runs as an iterative shift-add over WIDTH cycles.
- The bitwise inverter component is instantiated internally for NOT/NOR and for subtraction (A + ~B + 1).
- Sits between the register-file read stage and write-back, using a start/done handshake.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/bitwise_inverter.sv | 11 +
 rtl/shift_add_mul_32_bits.sv | 66 ++++++
 rtl/alu_seq_32_bits.sv | 141 ++++++++++++++
 tb/tb_alu_seq_32_bits.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential 32-bit ALU: opcodes, FSM states and
// default sizing for the shift-add multiplier.
package alu_pkg;

    localparam int WIDTH_DEF    = 32;
    localparam int MUL_ITER_DEF = WIDTH_DEF;
    localparam int MUL_CNT_W    = $clog2(MUL_ITER_DEF);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_MULU = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/bitwise_inverter.sv
// Bitwise inverter shared by NOT, NOR and the A + ~B + 1 subtract path.
module bitwise_inverter #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    assign y = ~a;

endmodule

// File: rtl/shift_add_mul_32_bits.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle while
// run is high; product_next carries the accumulator value of the current step.
module shift_add_mul_32_bits
    import alu_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int MUL_ITER = WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 run,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 last,
    output logic [2*WIDTH-1:0]   product_next
);

    localparam int CNT_W = (MUL_ITER > 1) ? $clog2(MUL_ITER) : 1;

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplr_q, mplr_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     partial;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;

        // 33-bit add into the upper half keeps the carry for the right shift.
        partial      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplr_q[0] ? {1'b0, mcand_q} : '0);
        product_next = {partial, acc_q[WIDTH-1:1]};
        last         = run && (cnt_q == CNT_W'(MUL_ITER - 1));

        if (start) begin
            mcand_d = a;
            mplr_d  = b;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (run) begin
            acc_d  = product_next;
            mplr_d = mplr_q >> 1;
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_seq_32_bits.sv
// Registered execute stage: single-cycle logic/arithmetic ops plus an
// iterative unsigned multiply, with a start/done handshake and Z/V flags.
module alu_seq_32_bits
    import alu_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int MUL_ITER = WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] H,
    output logic             Z,
    output logic             V,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] h_q, h_d;
    logic             z_q, z_d;
    logic             v_q, v_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0]   not_a, not_b, nor_ab;
    logic [WIDTH-1:0]   sum_add, sum_sub, alu_s;
    logic               v_add, v_sub, slt, alu_v;
    logic               mul_start, mul_run, mul_last;
    logic [2*WIDTH-1:0] mul_product;

    bitwise_inverter #(.WIDTH(WIDTH)) u_inv_a  (.a(A),     .y(not_a));
    bitwise_inverter #(.WIDTH(WIDTH)) u_inv_b  (.a(B),     .y(not_b));
    bitwise_inverter #(.WIDTH(WIDTH)) u_inv_or (.a(A | B), .y(nor_ab));

    assign mul_start = (state_q == ST_IDLE) && start && (op == OP_MULU);
    assign mul_run   = (state_q == ST_MUL);

    shift_add_mul_32_bits #(
        .WIDTH    (WIDTH),
        .MUL_ITER (MUL_ITER)
    ) u_mul (
        .clock        (clock),
        .reset        (reset),
        .start        (mul_start),
        .run          (mul_run),
        .a            (A),
        .b            (B),
        .last         (mul_last),
        .product_next (mul_product)
    );

    always_comb begin
        sum_add = A + B;
        sum_sub = A + not_b + WIDTH'(1);
        v_add   = (A[WIDTH-1] == B[WIDTH-1]) && (sum_add[WIDTH-1] != A[WIDTH-1]);
        v_sub   = (A[WIDTH-1] != B[WIDTH-1]) && (sum_sub[WIDTH-1] != A[WIDTH-1]);
        // True sign of A-B: raw sign bit corrected by overflow.
        slt     = sum_sub[WIDTH-1] ^ v_sub;

        alu_s = '0;
        alu_v = 1'b0;
        case (op)
            OP_AND: alu_s = A & B;
            OP_OR:  alu_s = A | B;
            OP_ADD: begin alu_s = sum_add; alu_v = v_add; end
            OP_NOT: alu_s = not_a;
            OP_NOR: alu_s = nor_ab;
            OP_SUB: begin alu_s = sum_sub; alu_v = v_sub; end
            OP_SLT: alu_s = {{(WIDTH-1){1'b0}}, slt};
            default: alu_s = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        h_d     = h_q;
        z_d     = z_q;
        v_d     = v_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (op == OP_MULU) begin
                        state_d = ST_MUL;
                    end else begin
                        s_d    = alu_s;
                        h_d    = '0;
                        z_d    = (alu_s == '0);
                        v_d    = alu_v;
                        done_d = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                // Results stay frozen until the final iteration lands.
                if (mul_last) begin
                    s_d     = mul_product[WIDTH-1:0];
                    h_d     = mul_product[2*WIDTH-1:WIDTH];
                    z_d     = (mul_product[WIDTH-1:0] == '0);
                    v_d     = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            h_q     <= '0;
            z_q     <= 1'b0;
            v_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            h_q     <= h_d;
            z_q     <= z_d;
            v_q     <= v_d;
            done_q  <= done_d;
        end
    end

    assign S    = s_q;
    assign H    = h_q;
    assign Z    = z_q;
    assign V    = v_q;
    assign busy = (state_q == ST_MUL);
    assign done = done_q;

endmodule

// File: tb/tb_alu_seq_32_bits.sv
// Scoreboard bench for alu_seq_32_bits: accepted requests push expected results
// computed with plain wide arithmetic; a monitor compares every cycle.
module tb_alu_seq_32_bits;
    import alu_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op    = 3'b000;
    logic [31:0] A     = 32'h0;
    logic [31:0] B     = 32'h0;
    logic [31:0] S, H;
    logic        Z, V, busy, done;

    always #5 clock = ~clock;

    alu_seq_32_bits #(.WIDTH(32), .MUL_ITER(32)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .S     (S),
        .H     (H),
        .Z     (Z),
        .V     (V),
        .busy  (busy),
        .done  (done)
    );

    typedef struct {
        logic [31:0] s;
        logic [31:0] h;
        logic        z;
        logic        v;
        int          due;
    } exp_t;

    exp_t sb_q[$];
    exp_t hold;
    exp_t mdl_e;
    int   cyc        = 0;
    int   n_checks   = 0;
    int   n_fail     = 0;
    bit   mul_active = 1'b0;
    int   mul_edge   = 0;
    bit   exp_busy, exp_done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic exp_t ref_model(input logic [2:0] f_op, input logic [31:0] a, input logic [31:0] b);
        exp_t               e;
        logic signed [63:0] sa, sb, wide;
        logic        [63:0] prod;
        sa   = $signed(a);
        sb   = $signed(b);
        wide = 64'sd0;
        prod = 64'd0;
        e.s = 32'h0; e.h = 32'h0; e.v = 1'b0; e.due = 0;
        case (f_op)
            OP_AND:  e.s = a & b;
            OP_OR:   e.s = a | b;
            OP_ADD:  begin
                wide = sa + sb;
                e.s  = wide[31:0];
                e.v  = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            OP_NOT:  e.s = ~a;
            OP_NOR:  e.s = ~(a | b);
            OP_MULU: begin
                prod = {32'h0, a} * {32'h0, b};
                e.h  = prod[63:32];
                e.s  = prod[31:0];
            end
            OP_SUB:  begin
                wide = sa - sb;
                e.s  = wide[31:0];
                e.v  = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            default: e.s = (sa < sb) ? 32'd1 : 32'd0;
        endcase
        e.z = (e.s == 32'h0);
        return e;
    endfunction

    // Reference model steps on the rising edge; monitor compares on the falling edge.
    always begin
        @(posedge clock);
        cyc++;
        if (reset) begin
            sb_q.delete();
            hold       = '{default: 0};
            mul_active = 1'b0;
        end else if (start && !(mul_active && cyc > mul_edge && cyc <= mul_edge + 32)) begin
            mdl_e = ref_model(op, A, B);
            if (op == OP_MULU) begin
                mdl_e.due  = cyc + 32;
                mul_active = 1'b1;
                mul_edge   = cyc;
            end else begin
                mdl_e.due = cyc;
            end
            sb_q.push_back(mdl_e);
        end

        @(negedge clock);
        exp_busy = mul_active && (cyc >= mul_edge) && (cyc <= mul_edge + 31);
        exp_done = (sb_q.size() > 0) && (sb_q[0].due == cyc);
        check("busy", {63'h0, busy}, {63'h0, exp_busy});
        check("done", {63'h0, done}, {63'h0, exp_done});
        if (exp_done) hold = sb_q.pop_front();
        if (mul_active && cyc >= mul_edge + 32) mul_active = 1'b0;
        check("S", {32'h0, S}, {32'h0, hold.s});
        check("H", {32'h0, H}, {32'h0, hold.h});
        check("Z", {63'h0, Z}, {63'h0, hold.z});
        check("V", {63'h0, V}, {63'h0, hold.v});
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(posedge clock);
        #2;
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
            start = 1'b0;
            op    = 3'($urandom);
            A     = $urandom;
            B     = $urandom;
        end
    endtask

    task automatic drain();
        int budget = 200;
        idle(1);
        while (sb_q.size() != 0 && budget > 0) begin
            idle(1);
            budget--;
        end
        if (budget == 0) begin
            $display("FAIL drain: scoreboard still holds %0d entries after cycle budget", sb_q.size());
            $fatal(1, "drain timeout");
        end
        idle(2);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] ro;
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        idle(3);

        issue(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001); idle(1);
        issue(OP_SUB, 32'd5, 32'd5);                  idle(1);
        issue(OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001);
        issue(OP_SLT, 32'h8000_0000, 32'h7FFF_FFFF);
        issue(OP_NOT, 32'h0F0F_0F0F, 32'h0);
        issue(OP_NOR, 32'h0, 32'h0);
        issue(OP_AND, 32'hF0F0_FFFF, 32'h0FF0_00FF);
        issue(OP_OR,  32'hF000_0000, 32'h0000_000F);
        drain();

        issue(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (5) begin
            issue(OP_ADD, $urandom, $urandom);
            idle(1);
        end
        drain();

        issue(OP_MULU, 32'h0001_0000, 32'h0001_0000);
        drain();

        // Abort a multiply at its tenth iteration.
        issue(OP_MULU, 32'h1234_5677, 32'h0000_0F0F);
        idle(10);
        reset = 1'b1;
        @(posedge clock);
        #2 reset = 1'b0;
        idle(3);
        issue(OP_ADD, 32'd3, 32'd4);
        drain();

        issue(OP_ADD, 32'd1, 32'd2);
        issue(OP_MULU, 32'd3, 32'd4);
        drain();

        repeat (60) begin
            ro = 3'($urandom_range(0, 7));
            issue(ro, rand_operand(), rand_operand());
            if (ro == OP_MULU && $urandom_range(0, 1) == 1) begin
                idle($urandom_range(1, 10));
                issue(3'($urandom_range(0, 7)), $urandom, $urandom);
            end
            idle($urandom_range(0, 2));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
